// File: rtl/parking_traffic_gen_if.sv
// Signal bundle between the vehicle-side traffic generator and its user/controller side.
// The generator uses the master modport; the controller or bench uses the slave modport.
interface parking_traffic_gen_if;
    logic       start;
    logic [1:0] wrong_attempts;
    logic       tailgate;
    logic       gateState;
    logic       blockAlarm;
    logic       wrongPinAlarm;
    logic       sensorA;
    logic       sensorB;
    logic [7:0] pass;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic       pin_alarm_seen;

    modport master (
        input  start, wrong_attempts, tailgate, gateState, blockAlarm, wrongPinAlarm,
        output sensorA, sensorB, pass, busy, done, result, pin_alarm_seen
    );

    modport slave (
        output start, wrong_attempts, tailgate, gateState, blockAlarm, wrongPinAlarm,
        input  sensorA, sensorB, pass, busy, done, result, pin_alarm_seen
    );
endinterface

// File: rtl/parking_traffic_gen.sv
// Vehicle-side driver for a parking-gate controller: plays one arrive/PIN/cross/exit
// transaction per start request and reports an outcome code.
module parking_traffic_gen #(
    parameter logic [7:0]  PIN          = 8'h7B,
    parameter int unsigned ARRIVE_CYC   = 4,
    parameter int unsigned PIN_HOLD     = 2,
    parameter int unsigned PIN_GAP      = 2,
    parameter int unsigned GATE_TIMEOUT = 20,
    parameter int unsigned CROSS_CYC    = 3,
    parameter int unsigned EXIT_CYC     = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    parking_traffic_gen_if.master  bus
);

    localparam logic [1:0] ResOk      = 2'b00;
    localparam logic [1:0] ResTimeout = 2'b01;
    localparam logic [1:0] ResBlocked = 2'b10;

    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [15:0] ArriveLd  = 16'(ARRIVE_CYC - 1);
    localparam logic [15:0] PinLd     = 16'(PIN_HOLD - 1);
    localparam logic [15:0] GapLd     = 16'(PIN_GAP - 1);
    localparam logic [15:0] TimeoutLd = 16'(GATE_TIMEOUT - 1);
    localparam logic [15:0] CrossLd   = 16'(CROSS_CYC - 1);
    localparam logic [15:0] ExitLd    = 16'(EXIT_CYC - 1);

    typedef enum logic [3:0] {
        StIdle, StArrive, StPin, StGap, StWait, StCross, StExit, StTail, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  attempt_q, attempt_d;
    logic [1:0]  wrong_q, wrong_d;
    logic        tail_q, tail_d;
    logic [1:0]  result_q, result_d;
    logic        alarm_q, alarm_d;
    logic        sensor_a_q, sensor_a_d;
    logic        sensor_b_q, sensor_b_d;
    logic [7:0]  pass_q, pass_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q != 16'd0) ? timer_q - 16'd1 : timer_q;
        attempt_d = attempt_q;
        wrong_d   = wrong_q;
        tail_d    = tail_q;
        result_d  = result_q;
        alarm_d   = alarm_q | ((state_q != StIdle) & bus.wrongPinAlarm);

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StArrive;
                    wrong_d   = bus.wrong_attempts;
                    tail_d    = bus.tailgate;
                    attempt_d = 2'd0;
                    result_d  = ResOk;
                    alarm_d   = 1'b0;
                end
            end
            StArrive: if (timer_q == 16'd0) state_d = StPin;
            StPin: begin
                if (timer_q == 16'd0) state_d = (attempt_q < wrong_q) ? StGap : StWait;
            end
            StGap: begin
                if (timer_q == 16'd0) begin
                    attempt_d = attempt_q + 2'd1;
                    state_d   = StPin;
                end
            end
            StWait: begin
                // A gate response in the final timeout cycle still counts.
                if (bus.gateState) begin
                    state_d = StCross;
                end else if (timer_q == 16'd0) begin
                    state_d  = StDone;
                    result_d = ResTimeout;
                end
            end
            StCross: if (timer_q == 16'd0) state_d = tail_q ? StTail : StExit;
            StExit: begin
                if (timer_q == 16'd0) begin
                    state_d  = StDone;
                    result_d = ResOk;
                end
            end
            StTail: begin
                if (timer_q == 16'd0) begin
                    state_d  = StDone;
                    result_d = ResTimeout;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Block alarm pre-empts whatever the active state wanted to do.
        if (bus.blockAlarm && state_q != StIdle && state_q != StDone) begin
            state_d  = StDone;
            result_d = ResBlocked;
        end

        if (state_d != state_q) begin
            case (state_d)
                StArrive: timer_d = ArriveLd;
                StPin:    timer_d = PinLd;
                StGap:    timer_d = GapLd;
                StWait:   timer_d = TimeoutLd;
                StCross:  timer_d = CrossLd;
                StExit:   timer_d = ExitLd;
                StTail:   timer_d = TimeoutLd;
                default:  timer_d = 16'd0;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registers track the state register.
    always_comb begin
        sensor_a_d = 1'b0;
        sensor_b_d = 1'b0;
        pass_d     = 8'h00;
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        case (state_d)
            StArrive, StGap, StWait: sensor_a_d = 1'b1;
            StPin: begin
                sensor_a_d = 1'b1;
                pass_d     = (attempt_d < wrong_d) ? (PIN ^ 8'hFF) : PIN;
            end
            StCross, StTail: begin
                sensor_a_d = 1'b1;
                sensor_b_d = 1'b1;
            end
            StExit:  sensor_b_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            timer_q    <= 16'd0;
            attempt_q  <= 2'd0;
            wrong_q    <= 2'd0;
            tail_q     <= 1'b0;
            result_q   <= 2'b00;
            alarm_q    <= 1'b0;
            sensor_a_q <= 1'b0;
            sensor_b_q <= 1'b0;
            pass_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            attempt_q  <= attempt_d;
            wrong_q    <= wrong_d;
            tail_q     <= tail_d;
            result_q   <= result_d;
            alarm_q    <= alarm_d;
            sensor_a_q <= sensor_a_d;
            sensor_b_q <= sensor_b_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.sensorA        = sensor_a_q;
    assign bus.sensorB        = sensor_b_q;
    assign bus.pass           = pass_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.result         = result_q;
    assign bus.pin_alarm_seen = alarm_q;

endmodule

// File: tb/tb_parking_traffic_gen.sv
// Directed bench for parking_traffic_gen: plays the controller side cycle by cycle.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_parking_traffic_gen;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    parking_traffic_gen_if bus_if ();

    parking_traffic_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // {sensorA, sensorB, pass, busy, done, result, pin_alarm_seen}
    function automatic logic [14:0] outs();
        return {bus_if.sensorA, bus_if.sensorB, bus_if.pass, bus_if.busy, bus_if.done,
                bus_if.result, bus_if.pin_alarm_seen};
    endfunction

    task automatic idle_inputs();
        bus_if.start          = 1'b0;
        bus_if.wrong_attempts = 2'd0;
        bus_if.tailgate       = 1'b0;
        bus_if.gateState      = 1'b0;
        bus_if.blockAlarm     = 1'b0;
        bus_if.wrongPinAlarm  = 1'b0;
    endtask

    // Returns at the falling edge of the first busy cycle (cycle 0).
    task automatic kick(input logic [1:0] wa, input logic tg);
        bus_if.start          = 1'b1;
        bus_if.wrong_attempts = wa;
        bus_if.tailgate       = tg;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", outs(), 15'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start busy got=%b exp=0", bus_if.busy);
        end
    endtask

    task automatic test_normal();
        logic [14:0] exp;
        kick(2'd0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            exp = {(i <= 12) ? 1'b1 : 1'b0, (i >= 10 && i <= 15) ? 1'b1 : 1'b0,
                   (i == 4 || i == 5) ? 8'h7B : 8'h00, 1'b1, (i == 16) ? 1'b1 : 1'b0,
                   2'b00, 1'b0};
            checks++;
            if (outs() !== exp) begin
                failures++;
                $display("FAIL normal cyc=%0d got=%h exp=%h", i, outs(), exp);
            end
            bus_if.gateState = (i >= 9);
            @(negedge clk);
        end
        bus_if.gateState = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            failures++;
            $display("FAIL normal_end busy/done got=%b%b exp=00", bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_wrong_pin();
        logic [7:0] exp_pass;
        logic       exp_alarm;
        kick(2'd2, 1'b0);
        for (int i = 0; i < 22; i++) begin
            if (i <= 13) begin
                exp_pass = (i == 4 || i == 5 || i == 8 || i == 9) ? 8'h84 :
                           (i == 12 || i == 13) ? 8'h7B : 8'h00;
                checks++;
                if (bus_if.pass !== exp_pass) begin
                    failures++;
                    $display("FAIL wrong_pin_pass cyc=%0d got=%h exp=%h", i, bus_if.pass, exp_pass);
                end
            end
            exp_alarm = (i >= 7);
            if (i == 6 || i == 7 || i == 21) begin
                checks++;
                if (bus_if.pin_alarm_seen !== exp_alarm) begin
                    failures++;
                    $display("FAIL wrong_pin_alarm cyc=%0d got=%b exp=%b", i,
                             bus_if.pin_alarm_seen, exp_alarm);
                end
            end
            if (i == 21) begin
                checks++;
                if (bus_if.done !== 1'b1 || bus_if.result !== 2'b00) begin
                    failures++;
                    $display("FAIL wrong_pin_done done=%b result=%b exp done=1 result=00",
                             bus_if.done, bus_if.result);
                end
            end
            bus_if.wrongPinAlarm = (i == 6);
            bus_if.gateState     = (i >= 14);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int wait_cnt = 0;
        kick(2'd0, 1'b0);
        for (int i = 0; i < 27; i++) begin
            if (i >= 6 && bus_if.sensorA && !bus_if.sensorB && bus_if.pass == 8'h00 &&
                !bus_if.done)
                wait_cnt++;
            if (i == 25) begin
                checks++;
                if (bus_if.sensorA !== 1'b1 || bus_if.done !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_last_wait sensorA=%b done=%b exp 1 0",
                             bus_if.sensorA, bus_if.done);
                end
            end
            if (i == 26) begin
                checks++;
                if (bus_if.done !== 1'b1 || bus_if.result !== 2'b01 || bus_if.sensorA !== 1'b0)
                begin
                    failures++;
                    $display("FAIL timeout_done done=%b result=%b sensorA=%b exp 1 01 0",
                             bus_if.done, bus_if.result, bus_if.sensorA);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (wait_cnt != 20) begin
            failures++;
            $display("FAIL timeout_wait_cycles got=%0d exp=20", wait_cnt);
        end
    endtask

    task automatic test_race_and_busy_start();
        kick(2'd0, 1'b0);
        for (int i = 0; i < 35; i++) begin
            if (i == 26) begin
                checks++;
                if (bus_if.sensorB !== 1'b1 || bus_if.done !== 1'b0) begin
                    failures++;
                    $display("FAIL race_cross sensorB=%b done=%b exp 1 0",
                             bus_if.sensorB, bus_if.done);
                end
            end
            if (i == 29) begin
                checks++;
                if (bus_if.sensorA !== 1'b0 || bus_if.sensorB !== 1'b1) begin
                    failures++;
                    $display("FAIL race_exit sensorA=%b sensorB=%b exp 0 1",
                             bus_if.sensorA, bus_if.sensorB);
                end
            end
            if (i == 32) begin
                checks++;
                if (bus_if.done !== 1'b1 || bus_if.result !== 2'b00) begin
                    failures++;
                    $display("FAIL race_done done=%b result=%b exp 1 00",
                             bus_if.done, bus_if.result);
                end
            end
            if (i == 33 || i == 34) begin
                checks++;
                if (bus_if.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_start_ignored cyc=%0d busy=%b exp 0", i, bus_if.busy);
                end
            end
            // start pulse with different settings while busy must be ignored
            bus_if.start          = (i == 10);
            bus_if.wrong_attempts = (i == 10) ? 2'd3 : 2'd0;
            bus_if.tailgate       = (i == 10);
            bus_if.gateState      = (i == 25);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_tailgate();
        kick(2'd0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            if (i == 10 || i == 15) begin
                checks++;
                if (bus_if.sensorA !== 1'b1 || bus_if.sensorB !== 1'b1 || bus_if.done !== 1'b0)
                begin
                    failures++;
                    $display("FAIL tail_hold cyc=%0d sensors=%b%b done=%b exp 11 0", i,
                             bus_if.sensorA, bus_if.sensorB, bus_if.done);
                end
            end
            if (i == 16) begin
                checks++;
                if (bus_if.done !== 1'b1 || bus_if.result !== 2'b10 ||
                    bus_if.sensorA !== 1'b0 || bus_if.sensorB !== 1'b0) begin
                    failures++;
                    $display("FAIL tail_blocked done=%b result=%b sensors=%b%b exp 1 10 00",
                             bus_if.done, bus_if.result, bus_if.sensorA, bus_if.sensorB);
                end
            end
            bus_if.gateState  = (i == 6);
            bus_if.blockAlarm = (i == 15);
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL tail_end busy=%b exp 0", bus_if.busy);
        end
    endtask

    task automatic test_block_early();
        kick(2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                checks++;
                if (bus_if.sensorA !== 1'b1 || bus_if.done !== 1'b0) begin
                    failures++;
                    $display("FAIL block_arrive sensorA=%b done=%b exp 1 0",
                             bus_if.sensorA, bus_if.done);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus_if.done !== 1'b1 || bus_if.result !== 2'b10 || bus_if.sensorA !== 1'b0)
                begin
                    failures++;
                    $display("FAIL block_early done=%b result=%b sensorA=%b exp 1 10 0",
                             bus_if.done, bus_if.result, bus_if.sensorA);
                end
            end
            bus_if.blockAlarm = (i == 1);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic saw_activity = 1'b0;
        kick(2'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus_if.gateState = (i == 6);
            @(negedge clk);
        end
        checks++;
        if (bus_if.sensorB !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_cross sensorB=%b exp 1", bus_if.sensorB);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 15'd0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=%h", outs(), 15'd0);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) saw_activity = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_activity !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%b exp=0", saw_activity);
        end
        test_normal();
    endtask

    task automatic test_back_to_back();
        bus_if.start     = 1'b1;
        bus_if.gateState = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (i == 13) begin
                checks++;
                if (bus_if.done !== 1'b1 || bus_if.result !== 2'b00) begin
                    failures++;
                    $display("FAIL b2b_first_done done=%b result=%b exp 1 00",
                             bus_if.done, bus_if.result);
                end
            end
            if (i == 14) begin
                checks++;
                if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_idle busy=%b done=%b exp 0 0", bus_if.busy, bus_if.done);
                end
            end
            if (i == 15) begin
                checks++;
                if (bus_if.busy !== 1'b1 || bus_if.sensorA !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_restart busy=%b sensorA=%b exp 1 1",
                             bus_if.busy, bus_if.sensorA);
                end
                bus_if.start = 1'b0;
            end
            if (i == 28) begin
                checks++;
                if (bus_if.done !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_second_done done=%b exp 1", bus_if.done);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_normal();
        test_wrong_pin();
        test_timeout();
        test_race_and_busy_start();
        test_tailgate();
        test_block_early();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_traffic_gen.md
# parking_traffic_gen

Synthesizable vehicle-side driver for the parking-gate interface. It produces the `sensorA`, `sensorB` and `pass` sequences that a parking-gate controller consumes, and it reacts to the controller's `gateState`, `blockAlarm` and `wrongPinAlarm`. It is used as the stimulus end of gate-controller benches and on FPGA demo boards in place of physical sensors and keypad. Each `start` request plays one complete vehicle transaction and reports an outcome code.

## Interface
- `PIN`, 8'h7B, correct access code driven on `pass`
- `ARRIVE_CYC`, 4, cycles `sensorA` is held alone before the first PIN attempt
- `PIN_HOLD`, 2, cycles each PIN attempt is driven on `pass`
- `PIN_GAP`, 2, cycles `pass`=0 between attempts
- `GATE_TIMEOUT`, 20, maximum wait cycles for a controller response
- `CROSS_CYC`, 3, cycles with both sensors high
- `EXIT_CYC`, 3, cycles with `sensorB` alone high
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous active-low reset
- `start` in 1 request one transaction; sampled only in IDLE
- `wrong_attempts` in 2 number of wrong PINs (`PIN ^ 8'hFF`) sent before the correct one
- `tailgate` in 1 a second car follows; provokes the block alarm
- `gateState` in 1 controller gate open
- `blockAlarm` in 1 controller block alarm
- `wrongPinAlarm` in 1 controller wrong-PIN alarm
- `sensorA` out 1 entry sensor
- `sensorB` out 1 exit sensor
- `pass` out 8 PIN bus; 0 when not in an attempt
- `busy` out 1 transaction in progress
- `done` out 1 one-cycle completion pulse
- `result` out 2 outcome: 00 OK, 01 TIMEOUT, 10 BLOCKED; held until next start
- `pin_alarm_seen` out 1 sticky: `wrongPinAlarm` sampled high during the transaction

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, counters 0.
- `start`, `wrong_attempts` and `tailgate` are latched on the IDLE→ARRIVE edge. `start` is ignored while `busy`.
- **IDLE**
  - `start`=1 → ARRIVE.
  - Clears `result` and `pin_alarm_seen`.
- **ARRIVE**
  - `sensorA`=1 for `ARRIVE_CYC` cycles → PIN.
- **PIN**
  - `sensorA`=1.
  - Drives `pass` = `PIN ^ 8'hFF` while attempt index < latched `wrong_attempts`, otherwise `PIN`.
  - Holds for `PIN_HOLD` cycles.
  - After a wrong attempt → GAP. After the correct attempt → WAIT.
- **GAP**
  - `sensorA`=1, `pass`=0 for `PIN_GAP` cycles.
  - Attempt index +1 (2-bit, cannot wrap: at most 3 wrong) → PIN.
- **WAIT**
  - `sensorA`=1, `pass`=0.
  - `gateState` sampled 1 → CROSS.
  - `GATE_TIMEOUT` cycles elapsed without it → DONE with TIMEOUT.
- **CROSS**
  - `sensorA`=`sensorB`=1 for `CROSS_CYC` cycles.
  - Latched `tailgate`=1 → TAIL; otherwise → EXIT.
- **EXIT**
  - `sensorA`=0, `sensorB`=1 for `EXIT_CYC` cycles → DONE with OK.
- **TAIL**
  - `sensorA`=`sensorB`=1.
  - Waits up to `GATE_TIMEOUT` cycles for `blockAlarm`; if it never arrives → DONE with TIMEOUT.
- **DONE**
  - Sensors 0, `pass` 0, `done`=1 for one cycle → IDLE.
- **Block alarm:** `blockAlarm` sampled 1 in any state other than IDLE or DONE → DONE with BLOCKED on the next edge. This overrides that state's own transition in the same cycle.
- **Wrong-PIN alarm:** `wrongPinAlarm` sampled 1 in any active state sets `pin_alarm_seen`. It does not change the state flow.
- **Timer:** one 16-bit down-counter, loaded on every state entry. All parameter values must fit in 16 bits and be ≥ 1.

## Timing
- `start` sampled at edge N → `busy`=1 and `sensorA`=1 visible after edge N.
- First `pass` attempt appears `ARRIVE_CYC` cycles after `sensorA` rises.
- Controller inputs are sampled each edge; the reaction appears one cycle later.
- `gateState` high in the same cycle the timeout expires → CROSS; the response wins.
- `busy` is high from ARRIVE through DONE inclusive and falls together with the `done` pulse's end.
- `result` is updated on the DONE entry edge and is valid while `done`=1.
- `rst_n` low mid-transaction: immediate return to IDLE with all outputs 0. No `done` pulse is produced.
- Back-to-back: `start` held high re-triggers on the first IDLE cycle after DONE.

## Test plan
- **Correct PIN, normal passage:** `start`, `wrong_attempts`=0, `tailgate`=0; controller raises `gateState` 3 cycles into WAIT → `pass`=8'h7B for 2 cycles, both sensors high for 3, `sensorB` alone for 3, `done` with `result`=00. Total 4+2+4+3+3+1 cycles of `busy`.
- **Wrong PINs, then correct:** `wrong_attempts`=2; controller pulses `wrongPinAlarm` → `pass` shows 8'h84, 0, 8'h84, 0, 8'h7B; `pin_alarm_seen`=1 at `done`; `result`=00.
- **Gate never opens:** `gateState` stuck 0 → exactly 20 WAIT cycles, then `done` with `result`=01; `sensorA` drops in the DONE cycle.
- **Tailgate:** `tailgate`=1; controller asserts `blockAlarm` 5 cycles into TAIL → `done` with `result`=10 on the next cycle.
- **Reset mid-transaction:** `rst_n` low during CROSS → all outputs 0 asynchronously, no `done`; a new `start` after release runs normally.
- **Start while busy, and race at timeout:** `start` pulsed while `busy` → ignored. `gateState` rising on the last WAIT cycle → CROSS, not TIMEOUT.
